// File: rtl/mem_hilo_unit.sv
// MEM-stage HI/LO owner: reduces multiplier partial products, selects
// HI/LO write data, stages writes in a one-entry pending buffer and
// bypasses that entry onto the read ports.
// Optional build macro: HILO_MADD_EN (selection 3 accumulates into HI/LO).
// Ports:
//   clk, resetn                    clock, async active-low reset
//   i_ena                          MEM advance / capture enable
//   i_MEM_RegHi_we/RegLo_we        per-half write enables
//   i_MEM_LoHi_wdata_selection     0 mult, 1 div, 2 opr2, 3 madd
//   i_MEM_opr2_value               MTHI/MTLO data
//   i_MEM_Div_quotient/remainder   div results (LO/HI)
//   i_MEM_mult_stage_0_result      four PP_W-bit partial products
//   i_MEM_mult_result_need_process negate the summed product
//   i_MEM_CP0_except_cause         5'h1f = no exception
//   o_hi, o_lo                     bypassed HI/LO
//   o_hilo_pending                 pending entry valid
module mem_hilo_unit #(
  parameter int PP_W = 42
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_ena,
  input  logic              i_MEM_RegHi_we,
  input  logic              i_MEM_RegLo_we,
  input  logic [1:0]        i_MEM_LoHi_wdata_selection,
  input  logic [31:0]       i_MEM_opr2_value,
  input  logic [31:0]       i_MEM_Div_quotient,
  input  logic [31:0]       i_MEM_Div_remainder,
  input  logic [4*PP_W-1:0] i_MEM_mult_stage_0_result,
  input  logic              i_MEM_mult_result_need_process,
  input  logic [4:0]        i_MEM_CP0_except_cause,
  output logic [31:0]       o_hi,
  output logic [31:0]       o_lo,
  output logic              o_hilo_pending
);

  typedef enum logic [1:0] {
    SEL_MULT = 2'd0,
    SEL_DIV  = 2'd1,
    SEL_OPR2 = 2'd2,
    SEL_MADD = 2'd3
  } wsel_e;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        pv_q, pv_d;
  logic        phwe_q, phwe_d;
  logic        plwe_q, plwe_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;

  logic [63:0] pp0, pp1, pp2, pp3;
  logic [63:0] prod_sum, prod;
  logic [63:0] wdata;
  logic        capture;
  wsel_e       sel;

  assign pp0 = 64'(i_MEM_mult_stage_0_result[0*PP_W +: PP_W]);
  assign pp1 = 64'(i_MEM_mult_stage_0_result[1*PP_W +: PP_W]);
  assign pp2 = 64'(i_MEM_mult_stage_0_result[2*PP_W +: PP_W]);
  assign pp3 = 64'(i_MEM_mult_stage_0_result[3*PP_W +: PP_W]);

  assign prod_sum = pp0 + (pp1 << 16) + (pp2 << 16) + (pp3 << 32);
  assign prod = i_MEM_mult_result_need_process ? -prod_sum : prod_sum;

  // Reads see the pending entry so back-to-back users get no bubble.
  assign o_hi = (pv_q && phwe_q) ? phi_q : hi_q;
  assign o_lo = (pv_q && plwe_q) ? plo_q : lo_q;
  assign o_hilo_pending = pv_q;

`ifdef HILO_MADD_EN
  logic [63:0] madd;
  assign madd = {o_hi, o_lo} + prod;
`endif

  assign sel = wsel_e'(i_MEM_LoHi_wdata_selection);

  always_comb begin
    wdata = prod;
    unique case (sel)
      SEL_MULT: wdata = prod;
      SEL_DIV:  wdata = {i_MEM_Div_remainder, i_MEM_Div_quotient};
      SEL_OPR2: wdata = {i_MEM_opr2_value, i_MEM_opr2_value};
`ifdef HILO_MADD_EN
      SEL_MADD: wdata = madd;
`else
      SEL_MADD: wdata = prod;
`endif
    endcase
  end

  assign capture = i_ena
                 && (i_MEM_RegHi_we || i_MEM_RegLo_we)
                 && (i_MEM_CP0_except_cause == 5'h1f);

  // Commit the old entry and load a new one in the same cycle if needed.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    pv_d   = pv_q;
    phwe_d = phwe_q;
    plwe_d = plwe_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    if (pv_q) begin
      if (phwe_q) hi_d = phi_q;
      if (plwe_q) lo_d = plo_q;
      pv_d = 1'b0;
    end
    if (capture) begin
      pv_d   = 1'b1;
      phwe_d = i_MEM_RegHi_we;
      plwe_d = i_MEM_RegLo_we;
      phi_d  = wdata[63:32];
      plo_d  = wdata[31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pv_q   <= 1'b0;
      phwe_q <= 1'b0;
      plwe_q <= 1'b0;
      phi_q  <= '0;
      plo_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pv_q   <= pv_d;
      phwe_q <= phwe_d;
      plwe_q <= plwe_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
    end
  end

endmodule

// File: tb/tb_mem_hilo_unit.sv
// Directed self-checking bench for mem_hilo_unit.
// Expected values are hand-computed constants.
module tb_mem_hilo_unit;

  localparam int PP_W = 42;

  logic              clk;
  logic              resetn;
  logic              i_ena;
  logic              hi_we;
  logic              lo_we;
  logic [1:0]        wsel;
  logic [31:0]       opr2;
  logic [31:0]       quo;
  logic [31:0]       rem;
  logic [4*PP_W-1:0] mres;
  logic              need;
  logic [4:0]        cause;
  logic [31:0]       o_hi;
  logic [31:0]       o_lo;
  logic              o_pend;

  int n_chk;
  int n_fail;

  mem_hilo_unit #(.PP_W(PP_W)) dut (
    .clk                            (clk),
    .resetn                         (resetn),
    .i_ena                          (i_ena),
    .i_MEM_RegHi_we                 (hi_we),
    .i_MEM_RegLo_we                 (lo_we),
    .i_MEM_LoHi_wdata_selection     (wsel),
    .i_MEM_opr2_value               (opr2),
    .i_MEM_Div_quotient             (quo),
    .i_MEM_Div_remainder            (rem),
    .i_MEM_mult_stage_0_result      (mres),
    .i_MEM_mult_result_need_process (need),
    .i_MEM_CP0_except_cause         (cause),
    .o_hi                           (o_hi),
    .o_lo                           (o_lo),
    .o_hilo_pending                 (o_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    i_ena = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wsel  = 2'd0;
    opr2  = '0;
    quo   = '0;
    rem   = '0;
    mres  = '0;
    need  = 1'b0;
    cause = 5'h1f;
  endtask

  task automatic set_pp(input logic [PP_W-1:0] a, input logic [PP_W-1:0] b,
                        input logic [PP_W-1:0] c, input logic [PP_W-1:0] d);
    mres = {d, c, b, a};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got %h:%h p%b want 0:0 p0", o_hi, o_lo, o_pend);
    end
  endtask

  task automatic test_mult();
    idle();
    i_ena = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wsel = 2'd0;
    set_pp(42'hFFFE0001, 42'hFFFE0001, 42'hFFFE0001, 42'hFFFE0001);
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
      n_fail++;
      $display("FAIL mult_bypass: got %h:%h p%b want fffffffe:00000001 p1",
               o_hi, o_lo, o_pend);
    end
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'hFFFFFFFE, 32'h00000001, 1'b0}) begin
      n_fail++;
      $display("FAIL mult_commit: got %h:%h p%b want fffffffe:00000001 p0",
               o_hi, o_lo, o_pend);
    end
  endtask

  task automatic test_sign();
    idle();
    i_ena = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wsel = 2'd0; need = 1'b1;
    set_pp(42'd6, 42'd0, 42'd0, 42'd0);
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1}) begin
      n_fail++;
      $display("FAIL mult_neg: got %h:%h p%b want ffffffff:fffffffa p1",
               o_hi, o_lo, o_pend);
    end
    step();
  endtask

  task automatic test_div_cancel();
    idle();
    i_ena = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wsel = 2'd1;
    quo = 32'd7; rem = 32'd3;
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd3, 32'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL div: got %h:%h p%b want 3:7 p1", o_hi, o_lo, o_pend);
    end
    i_ena = 1'b1; hi_we = 1'b1; wsel = 2'd2;
    opr2 = 32'h12345678; cause = 5'h0c;
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd3, 32'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL cancel_mthi: got %h:%h p%b want 3:7 p0",
               o_hi, o_lo, o_pend);
    end
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd3, 32'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL cancel_hold: got %h:%h p%b want 3:7 p0",
               o_hi, o_lo, o_pend);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
`ifdef HILO_MADD_EN
    e1 = 64'h00000001_00000000;
    e2 = 64'h00000001_00000001;
`else
    e1 = 64'h00000000_00000001;
    e2 = 64'h00000000_00000001;
`endif
    idle();
    i_ena = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wsel = 2'd0;
    set_pp(42'hFFFFFFFF, 42'd0, 42'd0, 42'd0);
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'h0, 32'hFFFFFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL madd_init: got %h:%h p%b want 0:ffffffff p1",
               o_hi, o_lo, o_pend);
    end
    wsel = 2'd3;
    set_pp(42'd1, 42'd0, 42'd0, 42'd0);
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {e1, 1'b1}) begin
      n_fail++;
      $display("FAIL madd_first: got %h:%h p%b want %h p1",
               o_hi, o_lo, o_pend, e1);
    end
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {e2, 1'b1}) begin
      n_fail++;
      $display("FAIL madd_second: got %h:%h p%b want %h p1",
               o_hi, o_lo, o_pend, e2);
    end
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {e2, 1'b0}) begin
      n_fail++;
      $display("FAIL madd_commit: got %h:%h p%b want %h p0",
               o_hi, o_lo, o_pend, e2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ehi;
`ifdef HILO_MADD_EN
    ehi = 32'd1;
`else
    ehi = 32'd0;
`endif
    idle();
    lo_we = 1'b1; wsel = 2'd2; opr2 = 32'hA5;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({o_lo, o_pend} !== {32'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_%0d: got lo=%h p%b want lo=1 p0",
                 i, o_lo, o_pend);
      end
    end
    i_ena = 1'b1;
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {ehi, 32'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_release: got %h:%h p%b want %h:a5 p1",
               o_hi, o_lo, o_pend, ehi);
    end
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {ehi, 32'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_commit: got %h:%h p%b want %h:a5 p0",
               o_hi, o_lo, o_pend, ehi);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    i_ena = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wsel = 2'd0;
    set_pp(42'd5, 42'd0, 42'd0, 42'd0);
    step();
    idle();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd0, 32'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_pre: got %h:%h p%b want 0:5 p1",
               o_hi, o_lo, o_pend);
    end
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: got %h:%h p%b want 0:0 p0",
               o_hi, o_lo, o_pend);
    end
    step();
    resetn = 1'b1;
    step();
    n_chk++;
    if ({o_hi, o_lo, o_pend} !== {32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after: got %h:%h p%b want 0:0 p0",
               o_hi, o_lo, o_pend);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    resetn = 1'b0;
    #12;
    test_reset();
    resetn = 1'b1;
    step();
    test_mult();
    test_sign();
    test_div_cancel();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
